lsu_multicycle: RTL and testbench
=================================

# lsu_multicycle

Parametrised multi-cycle load/store unit for the NPC execute stage. It takes over the memory work the single-cycle execute block did through direct DPI calls, and replaces them with a valid/ready request/response bus. It supports all RV32/RV64 load and store widths with sign/zero extension, byte-lane write strobes, misalignment detection and a bus timeout. It sits between the execute stage, which supplies base, immediate and store data, and the writeback stage, which consumes rd/data/exception.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 and 64.
- `TIMEOUT_CYCLES`, 256, cycles allowed in REQ+WAIT before abort; 0 disables the timeout.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `in_valid`  in  1  execute stage offers a memory op.
- `in_ready`  out  1  high only in IDLE and not in reset.
- `in_is_store`  in  1  1 = store, 0 = load.
- `in_funct3`  in  3  RISC-V funct3 (size/sign).
- `in_base`  in  XLEN  rs1 value.
- `in_imm`  in  12  I/S immediate, sign-extended to XLEN.
- `in_wdata`  in  XLEN  rs2 value (stores).
- `in_rd`  in  5  destination register (loads).
- `mem_req_valid`  out  1  bus request.
- `mem_req_ready`  in  1  bus accepts request.
- `mem_req_addr`  out  XLEN  effective address with low log2(XLEN/8) bits cleared.
- `mem_req_wen`  out  1  write request.
- `mem_req_wdata`  out  XLEN  store data shifted into its byte lanes.
- `mem_req_wstrb`  out  XLEN/8  byte-lane strobe; all-ones for loads.
- `mem_rsp_valid`  in  1  read data, or write acknowledge.
- `mem_rsp_rdata`  in  XLEN  full aligned word.
- `mem_rsp_ready`  out  1  high in WAIT and IDLE.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  writeback accepts.
- `out_gpr_wen`  out  1  load completed without exception and rd≠0.
- `out_rd`  out  5  latched rd.
- `out_data`  out  XLEN  extended load data; 0 for stores and on exception.
- `out_exc`  out  2  0 = none, 1 = misaligned, 2 = bus timeout, 3 = illegal funct3.
- `out_addr`  out  XLEN  full unaligned effective address (for mtval).

## Operation
- States are IDLE, REQ, WAIT, DONE.
- Effective address: `ea = in_base + sext(in_imm)`, computed modulo 2^XLEN; it is latched at accept together with funct3, is_store, wdata and rd.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU only when XLEN=64.
  - Stores: 000 SB, 001 SH, 010 SW; 011 SD only when XLEN=64.
  - Anything else gives exc=3.
- Misaligned: `ea` is not a multiple of the access size. This gives exc=1.
- IDLE:
  - `in_valid && in_ready` → REQ if the op is legal and aligned.
  - Otherwise → DONE with the exception, issuing no bus traffic.
- REQ:
  - `mem_req_valid=1`; request fields are held stable until `mem_req_ready`.
  - Handshake → WAIT.
- WAIT:
  - `mem_rsp_valid` → DONE.
  - Loads select bytes at offset `ea[log2(XLEN/8)-1:0]`, then sign-extend or zero-extend per funct3.
  - Stores ignore rdata.
- DONE:
  - `out_valid=1`; all out_* are held until `out_ready`, then → IDLE.
- Timeout:
  - The counter clears on accept and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES → DONE with exc=2; `mem_req_valid` drops even if not accepted.
  - A response arriving later is consumed in IDLE and discarded.
- Store lanes: for SB at lane k, `wstrb = 1<<k` and `wdata = wdata[7:0]` replicated/shifted to lane k. SH and SW follow the same pattern.
- A response arriving in IDLE, REQ or DONE is ignored and never produces an output.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready=0` while `rst`.
  - `mem_req_valid`, `mem_req_wen`, `mem_req_addr`, `mem_req_wdata`, `mem_req_wstrb`, `out_valid`, `out_gpr_wen`, `out_rd`, `out_data`, `out_exc`, `out_addr` are all 0.
  - `mem_rsp_ready=1`.
- Accept at edge N:
  - `mem_req_valid` is high in cycle N+1.
  - If ready in N+1 and the response arrives in N+2, then `out_valid` is high in N+3. This is the minimum latency of 3 cycles.
- Exception without bus access: accept at N → `out_valid` in N+1.
- All bus-side and out-side outputs are registered; `in_ready` and `mem_rsp_ready` are decoded from state.
- The unit has one op in flight; it cannot accept a new op in the same cycle `out_valid` handshakes. The next accept is possible one cycle later.
- Reset mid-operation returns to IDLE next edge and drops any request. A response pending across reset is discarded in IDLE.

## Test plan
- LW, base=0x8000_0000, imm=4, rdata=0xDEAD_BEEF, req ready 1st cycle, response next cycle → addr 0x8000_0004, wstrb 0xF, `out_data` 0xDEADBEEF, `out_gpr_wen`=1, `out_valid` 3 cycles after accept.
- LB at ea 0x8000_0003 with rdata 0x80FF_0000 → 0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at ea+2 (0x8000_0002) → 0x0000_80FF.
- SB, ea 0x8000_0002, wdata 0x1234_56AB → wen=1, wstrb 0b0100, wdata[23:16]=0xAB. SH at 0x8000_0003 → exc=1 with no `mem_req_valid`, `out_valid` 1 cycle after accept.
- TIMEOUT_CYCLES=4, `mem_req_ready` held 0 → `mem_req_valid` drops after 4 cycles, `out_exc`=2, `out_gpr_wen`=0. A late response is discarded with no second `out_valid`.
- `out_ready` held low 5 cycles in DONE → out_* stable, `in_ready`=0 throughout. Assert `rst` while in WAIT → next cycle state IDLE, `mem_req_valid`=0, `out_valid`=0.
- XLEN=64: LD at 0x10 with rdata 0x0123_4567_89AB_CDEF → same value out. LWU at 0x14 → 0x0000_0000_0123_4567. funct3=011 with XLEN=32 → exc=3.

Source files
------------

// File: rtl/lsu_multicycle_if.sv
// Execute-side request, memory bus and writeback-side result signals of the LSU.
// The master modport is the LSU's view; the slave modport is its environment.
interface lsu_multicycle_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned NB = XLEN / 8;

  logic            in_valid;
  logic            in_ready;
  logic            in_is_store;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_base;
  logic [11:0]     in_imm;
  logic [XLEN-1:0] in_wdata;
  logic [4:0]      in_rd;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_wen;
  logic [XLEN-1:0] mem_req_wdata;
  logic [NB-1:0]   mem_req_wstrb;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;
  logic            mem_rsp_ready;

  logic            out_valid;
  logic            out_ready;
  logic            out_gpr_wen;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic [1:0]      out_exc;
  logic [XLEN-1:0] out_addr;

  modport master (
    input  in_valid, in_is_store, in_funct3, in_base, in_imm, in_wdata, in_rd,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
    output mem_req_wstrb, mem_rsp_ready, out_valid, out_gpr_wen, out_rd,
    output out_data, out_exc, out_addr
  );

  modport slave (
    output in_valid, in_is_store, in_funct3, in_base, in_imm, in_wdata, in_rd,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
    input  mem_req_wstrb, mem_rsp_ready, out_valid, out_gpr_wen, out_rd,
    input  out_data, out_exc, out_addr
  );
endinterface

// File: rtl/lsu_multicycle.sv
// Multi-cycle load/store unit: decodes one execute-stage memory op, issues a
// single aligned bus request and returns extended load data or an exception.
module lsu_multicycle #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic              clk,
  input logic              rst,
  lsu_multicycle_if.master bus
);
  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] ea_q;
  logic [2:0]      funct3_q;
  logic            is_store_q;
  logic [4:0]      rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic            mem_req_valid_q;
  logic            mem_req_wen_q;
  logic [XLEN-1:0] mem_req_addr_q;
  logic [XLEN-1:0] mem_req_wdata_q;
  logic [NB-1:0]   mem_req_wstrb_q;
  logic            out_valid_q;
  logic            out_gpr_wen_q;
  logic [4:0]      out_rd_q;
  logic [XLEN-1:0] out_data_q;
  logic [1:0]      out_exc_q;
  logic [XLEN-1:0] out_addr_q;

  logic [XLEN-1:0]  ea_c;
  logic             legal_c;
  logic [OFF_W-1:0] size_mask_c;
  logic             misal_c;
  logic [XLEN-1:0]  lane_mask_c;
  logic [NB-1:0]    strb_base_c;
  logic [XLEN-1:0]  st_wdata_c;
  logic [NB-1:0]    st_wstrb_c;
  logic [XLEN-1:0]  rsh_c;
  logic [XLEN-1:0]  load_c;
  logic             timeout_c;

  assign ea_c = bus.in_base + {{(XLEN-12){bus.in_imm[11]}}, bus.in_imm};

  // funct3 legality; the doubleword and LWU encodings exist only on RV64
  always_comb begin
    legal_c = 1'b0;
    if (bus.in_is_store) begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010: legal_c = 1'b1;
        3'b011:                 legal_c = (XLEN == 64);
        default:                legal_c = 1'b0;
      endcase
    end else begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_c = 1'b1;
        3'b011, 3'b110:                         legal_c = (XLEN == 64);
        default:                                legal_c = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (bus.in_funct3[1:0])
      2'd0: begin
        size_mask_c = '0;
        lane_mask_c = XLEN'(8'hFF);
        strb_base_c = NB'(1'b1);
      end
      2'd1: begin
        size_mask_c = OFF_W'(1);
        lane_mask_c = XLEN'(16'hFFFF);
        strb_base_c = NB'(2'b11);
      end
      2'd2: begin
        size_mask_c = OFF_W'(3);
        lane_mask_c = XLEN'(32'hFFFF_FFFF);
        strb_base_c = NB'(4'hF);
      end
      default: begin
        size_mask_c = OFF_W'(7);
        lane_mask_c = '1;
        strb_base_c = '1;
      end
    endcase
    st_wdata_c = (bus.in_wdata & lane_mask_c) << {ea_c[OFF_W-1:0], 3'b000};
    st_wstrb_c = strb_base_c << ea_c[OFF_W-1:0];
  end

  assign misal_c = (ea_c[OFF_W-1:0] & size_mask_c) != '0;

  // Pick the addressed bytes out of the aligned word, then extend
  always_comb begin
    rsh_c = bus.mem_rsp_rdata >> {ea_q[OFF_W-1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_c = XLEN'($signed(rsh_c[7:0]));
      3'b001:  load_c = XLEN'($signed(rsh_c[15:0]));
      3'b010:  load_c = XLEN'($signed(rsh_c[31:0]));
      3'b100:  load_c = XLEN'(rsh_c[7:0]);
      3'b101:  load_c = XLEN'(rsh_c[15:0]);
      3'b110:  load_c = XLEN'(rsh_c[31:0]);
      default: load_c = rsh_c;
    endcase
  end

  assign timeout_c = (TIMEOUT_CYCLES != 0) &&
                     ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      ea_q            <= '0;
      funct3_q        <= '0;
      is_store_q      <= 1'b0;
      rd_q            <= '0;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_wen_q   <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_wstrb_q <= '0;
      out_valid_q     <= 1'b0;
      out_gpr_wen_q   <= 1'b0;
      out_rd_q        <= '0;
      out_data_q      <= '0;
      out_exc_q       <= EXC_NONE;
      out_addr_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            ea_q       <= ea_c;
            funct3_q   <= bus.in_funct3;
            is_store_q <= bus.in_is_store;
            rd_q       <= bus.in_rd;
            cnt_q      <= '0;
            if (!legal_c || misal_c) begin
              state_q       <= S_DONE;
              out_valid_q   <= 1'b1;
              out_exc_q     <= legal_c ? EXC_MISALIGN : EXC_ILLEGAL;
              out_data_q    <= '0;
              out_gpr_wen_q <= 1'b0;
              out_rd_q      <= bus.in_rd;
              out_addr_q    <= ea_c;
            end else begin
              state_q         <= S_REQ;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= {ea_c[XLEN-1:OFF_W], OFF_W'(0)};
              mem_req_wen_q   <= bus.in_is_store;
              mem_req_wdata_q <= bus.in_is_store ? st_wdata_c : '0;
              mem_req_wstrb_q <= bus.in_is_store ? st_wstrb_c : '1;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.mem_req_ready) begin
            state_q         <= S_WAIT;
            mem_req_valid_q <= 1'b0;
          end else if (timeout_c) begin
            state_q         <= S_DONE;
            mem_req_valid_q <= 1'b0;
            out_valid_q     <= 1'b1;
            out_exc_q       <= EXC_TIMEOUT;
            out_data_q      <= '0;
            out_gpr_wen_q   <= 1'b0;
            out_rd_q        <= rd_q;
            out_addr_q      <= ea_q;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.mem_rsp_valid) begin
            state_q       <= S_DONE;
            out_valid_q   <= 1'b1;
            out_exc_q     <= EXC_NONE;
            out_data_q    <= is_store_q ? '0 : load_c;
            out_gpr_wen_q <= !is_store_q && (rd_q != 5'd0);
            out_rd_q      <= rd_q;
            out_addr_q    <= ea_q;
          end else if (timeout_c) begin
            state_q       <= S_DONE;
            out_valid_q   <= 1'b1;
            out_exc_q     <= EXC_TIMEOUT;
            out_data_q    <= '0;
            out_gpr_wen_q <= 1'b0;
            out_rd_q      <= rd_q;
            out_addr_q    <= ea_q;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (state_q == S_IDLE) && !rst;
  assign bus.mem_rsp_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_wen   = mem_req_wen_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_wdata = mem_req_wdata_q;
  assign bus.mem_req_wstrb = mem_req_wstrb_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_gpr_wen   = out_gpr_wen_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_exc       = out_exc_q;
  assign bus.out_addr      = out_addr_q;
endmodule

// File: tb/tb_lsu_multicycle.sv
// Directed bench for lsu_multicycle: an RV32 unit with a short bus timeout and
// an RV64 unit, driven from one shared stimulus set selected by sel64.
module tb_lsu_multicycle;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit          sel64;
  logic        d_in_valid, d_is_store, d_req_ready, d_rsp_valid, d_out_ready;
  logic [2:0]  d_funct3;
  logic [63:0] d_base, d_wdata, d_rdata;
  logic [11:0] d_imm;
  logic [4:0]  d_rd;
  int          errors = 0;
  int          checks = 0;

  lsu_multicycle_if #(.XLEN(32)) if32 ();
  lsu_multicycle_if #(.XLEN(64)) if64 ();

  lsu_multicycle #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut32 (.clk(clk), .rst(rst), .bus(if32.master));
  lsu_multicycle #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(if64.master));

  assign if32.in_valid      = d_in_valid & ~sel64;
  assign if32.in_is_store   = d_is_store;
  assign if32.in_funct3     = d_funct3;
  assign if32.in_base       = d_base[31:0];
  assign if32.in_imm        = d_imm;
  assign if32.in_wdata      = d_wdata[31:0];
  assign if32.in_rd         = d_rd;
  assign if32.mem_req_ready = d_req_ready;
  assign if32.mem_rsp_valid = d_rsp_valid & ~sel64;
  assign if32.mem_rsp_rdata = d_rdata[31:0];
  assign if32.out_ready     = d_out_ready & ~sel64;

  assign if64.in_valid      = d_in_valid & sel64;
  assign if64.in_is_store   = d_is_store;
  assign if64.in_funct3     = d_funct3;
  assign if64.in_base       = d_base;
  assign if64.in_imm        = d_imm;
  assign if64.in_wdata      = d_wdata;
  assign if64.in_rd         = d_rd;
  assign if64.mem_req_ready = d_req_ready;
  assign if64.mem_rsp_valid = d_rsp_valid & sel64;
  assign if64.mem_rsp_rdata = d_rdata;
  assign if64.out_ready     = d_out_ready & sel64;

  logic        t_in_ready, t_rsp_ready, t_req_valid, t_req_wen, t_out_valid, t_out_gpr;
  logic [63:0] t_req_addr, t_req_wdata, t_out_data, t_out_addr;
  logic [7:0]  t_req_wstrb;
  logic [4:0]  t_out_rd;
  logic [1:0]  t_out_exc;

  always_comb begin
    if (sel64) begin
      t_in_ready  = if64.in_ready;       t_rsp_ready = if64.mem_rsp_ready;
      t_req_valid = if64.mem_req_valid;  t_req_wen   = if64.mem_req_wen;
      t_req_addr  = if64.mem_req_addr;   t_req_wdata = if64.mem_req_wdata;
      t_req_wstrb = if64.mem_req_wstrb;  t_out_valid = if64.out_valid;
      t_out_gpr   = if64.out_gpr_wen;    t_out_rd    = if64.out_rd;
      t_out_data  = if64.out_data;       t_out_exc   = if64.out_exc;
      t_out_addr  = if64.out_addr;
    end else begin
      t_in_ready  = if32.in_ready;               t_rsp_ready = if32.mem_rsp_ready;
      t_req_valid = if32.mem_req_valid;          t_req_wen   = if32.mem_req_wen;
      t_req_addr  = 64'(if32.mem_req_addr);      t_req_wdata = 64'(if32.mem_req_wdata);
      t_req_wstrb = 8'(if32.mem_req_wstrb);      t_out_valid = if32.out_valid;
      t_out_gpr   = if32.out_gpr_wen;            t_out_rd    = if32.out_rd;
      t_out_data  = 64'(if32.out_data);          t_out_exc   = if32.out_exc;
      t_out_addr  = 64'(if32.out_addr);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one op for a single cycle; returns at the first negedge after accept
  task automatic launch(input bit is_st, input logic [2:0] f3, input logic [63:0] base,
                        input logic [11:0] imm, input logic [63:0] wd, input logic [4:0] rd);
    @(negedge clk);
    d_in_valid = 1'b1; d_is_store = is_st; d_funct3 = f3;
    d_base = base; d_imm = imm; d_wdata = wd; d_rd = rd;
    @(negedge clk);
    d_in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input bit is_st, input logic [2:0] f3,
                        input logic [63:0] base, input logic [11:0] imm, input logic [63:0] wd,
                        input logic [4:0] rd, input logic [63:0] rdata,
                        input logic [63:0] e_addr, input logic [7:0] e_strb,
                        input logic [63:0] e_wmask, input logic [63:0] e_wdata,
                        input logic [63:0] e_data, input logic e_gpr, input logic [1:0] e_exc,
                        input logic [63:0] e_oaddr);
    logic req_seen;
    launch(is_st, f3, base, imm, wd, rd);
    req_seen = t_req_valid;
    check({tag, ".req_valid"}, req_seen, e_exc == 2'd0);
    if (req_seen) begin
      check({tag, ".addr"}, t_req_addr, e_addr);
      check({tag, ".wstrb"}, t_req_wstrb, e_strb);
      check({tag, ".wen"}, t_req_wen, is_st);
      if (is_st) check({tag, ".wdata"}, t_req_wdata & e_wmask, e_wdata);
      @(negedge clk);
      d_rsp_valid = 1'b1; d_rdata = rdata;
      @(negedge clk);
      d_rsp_valid = 1'b0;
    end
    check({tag, ".out_valid"}, t_out_valid, 1'b1);
    check({tag, ".exc"}, t_out_exc, e_exc);
    check({tag, ".data"}, t_out_data, e_data);
    check({tag, ".gpr_wen"}, t_out_gpr, e_gpr);
    check({tag, ".out_addr"}, t_out_addr, e_oaddr);
    check({tag, ".rd"}, t_out_rd, rd);
    d_out_ready = 1'b1;
    @(negedge clk);
    d_out_ready = 1'b0;
    check({tag, ".idle"}, {t_out_valid, t_in_ready}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   n_req;
    rst = 1'b1; sel64 = 1'b0;
    d_in_valid = 1'b0; d_is_store = 1'b0; d_funct3 = '0; d_base = '0; d_imm = '0;
    d_wdata = '0; d_rd = '0; d_req_ready = 1'b1; d_rsp_valid = 1'b0; d_rdata = '0;
    d_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready", t_in_ready, 1'b0);
    check("rst.rsp_ready", t_rsp_ready, 1'b1);
    check("rst.req_valid", t_req_valid, 1'b0);
    check("rst.out_valid", t_out_valid, 1'b0);
    check("rst.out_data", t_out_data, 64'h0);
    check("rst.out_exc", t_out_exc, 2'd0);
    rst = 1'b0;

    // RV32 directed ops
    run_op("lw",   0, 3'b010, 64'h8000_0000, 12'h004, 64'h0, 5'd5, 64'hDEAD_BEEF,
           64'h8000_0004, 8'hF, 64'h0, 64'h0, 64'hDEAD_BEEF, 1'b1, 2'd0, 64'h8000_0004);
    run_op("lb",   0, 3'b000, 64'h8000_0000, 12'h003, 64'h0, 5'd6, 64'h80FF_0000,
           64'h8000_0000, 8'hF, 64'h0, 64'h0, 64'hFFFF_FF80, 1'b1, 2'd0, 64'h8000_0003);
    run_op("lbu",  0, 3'b100, 64'h8000_0000, 12'h003, 64'h0, 5'd6, 64'h80FF_0000,
           64'h8000_0000, 8'hF, 64'h0, 64'h0, 64'h0000_0080, 1'b1, 2'd0, 64'h8000_0003);
    run_op("lhu",  0, 3'b101, 64'h8000_0000, 12'h002, 64'h0, 5'd7, 64'h80FF_0000,
           64'h8000_0000, 8'hF, 64'h0, 64'h0, 64'h0000_80FF, 1'b1, 2'd0, 64'h8000_0002);
    run_op("lh",   0, 3'b001, 64'h8000_0000, 12'h002, 64'h0, 5'd7, 64'h80FF_0000,
           64'h8000_0000, 8'hF, 64'h0, 64'h0, 64'hFFFF_80FF, 1'b1, 2'd0, 64'h8000_0002);
    run_op("lw_rd0", 0, 3'b010, 64'h4000, 12'h000, 64'h0, 5'd0, 64'h1234_5678,
           64'h4000, 8'hF, 64'h0, 64'h0, 64'h1234_5678, 1'b0, 2'd0, 64'h4000);
    run_op("sb",   1, 3'b000, 64'h8000_0000, 12'h002, 64'h1234_56AB, 5'd0, 64'hFFFF_FFFF,
           64'h8000_0000, 8'h4, 64'h00FF_0000, 64'h00AB_0000, 64'h0, 1'b0, 2'd0, 64'h8000_0002);
    run_op("sh_mis", 1, 3'b001, 64'h8000_0000, 12'h003, 64'h1234, 5'd0, 64'h0,
           64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b0, 2'd1, 64'h8000_0003);
    run_op("sw_neg", 1, 3'b010, 64'h1000, 12'hFFC, 64'hCAFE_F00D, 5'd0, 64'h0,
           64'h0FFC, 8'hF, 64'hFFFF_FFFF, 64'hCAFE_F00D, 64'h0, 1'b0, 2'd0, 64'h0FFC);
    run_op("sh_hi", 1, 3'b001, 64'h2000, 12'h002, 64'hABCD, 5'd0, 64'h0,
           64'h2000, 8'hC, 64'hFFFF_0000, 64'hABCD_0000, 64'h0, 1'b0, 2'd0, 64'h2002);
    run_op("lh_mis", 0, 3'b001, 64'h2000, 12'h001, 64'h0, 5'd4, 64'h0,
           64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b0, 2'd1, 64'h2001);
    run_op("ld32", 0, 3'b011, 64'h3000, 12'h000, 64'h0, 5'd8, 64'h0,
           64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b0, 2'd3, 64'h3000);
    run_op("lwu32", 0, 3'b110, 64'h3000, 12'h004, 64'h0, 5'd8, 64'h0,
           64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b0, 2'd3, 64'h3004);
    run_op("st_bad", 1, 3'b100, 64'h3000, 12'h000, 64'h0, 5'd0, 64'h0,
           64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b0, 2'd3, 64'h3000);

    // Bus never accepts: request withdrawn after four cycles with a timeout
    d_req_ready = 1'b0;
    launch(0, 3'b010, 64'h100, 12'h000, 64'h0, 5'd3);
    n_req = 0;
    for (int i = 0; i < 20 && !t_out_valid; i++) begin
      if (t_req_valid) n_req++;
      @(negedge clk);
    end
    check("to.req_cycles", 64'(n_req), 64'd4);
    check("to.out_valid", t_out_valid, 1'b1);
    check("to.req_dropped", t_req_valid, 1'b0);
    check("to.exc", t_out_exc, 2'd2);
    check("to.gpr_wen", t_out_gpr, 1'b0);
    check("to.data", t_out_data, 64'h0);
    d_req_ready = 1'b1; d_out_ready = 1'b1;
    @(negedge clk);
    d_out_ready = 1'b0; d_rsp_valid = 1'b1; d_rdata = 64'h5555_5555;
    @(negedge clk);
    d_rsp_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (t_out_valid !== 1'b0 || t_in_ready !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    check("to.late_rsp_dropped", ok, 1'b1);

    // Writeback stalls: result must hold and no new op may be accepted
    launch(0, 3'b010, 64'h8000_0000, 12'h008, 64'h0, 5'd7);
    @(negedge clk);
    d_rsp_valid = 1'b1; d_rdata = 64'hDEAD_BEEF;
    @(negedge clk);
    d_rsp_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(t_out_valid === 1'b1 && t_out_data === 64'hDEAD_BEEF && t_in_ready === 1'b0 &&
            t_out_rd === 5'd7 && t_out_addr === 64'h8000_0008 && t_out_gpr === 1'b1)) ok = 1'b0;
      @(negedge clk);
    end
    check("stall.stable", ok, 1'b1);
    d_out_ready = 1'b1;
    @(negedge clk);
    d_out_ready = 1'b0;
    check("stall.released", t_out_valid, 1'b0);

    // Reset while waiting for the response
    launch(0, 3'b010, 64'h600, 12'h000, 64'h0, 5'd2);
    @(negedge clk);
    check("rstw.in_wait", {t_req_valid, t_rsp_ready, t_in_ready}, 3'b010);
    rst = 1'b1;
    @(negedge clk);
    check("rstw.req_valid", t_req_valid, 1'b0);
    check("rstw.out_valid", t_out_valid, 1'b0);
    check("rstw.in_ready", t_in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rstw.idle", t_in_ready, 1'b1);
    d_rsp_valid = 1'b1; d_rdata = 64'h7777_7777;
    @(negedge clk);
    d_rsp_valid = 1'b0;
    check("rstw.rsp_dropped", t_out_valid, 1'b0);
    run_op("rstw.recover", 0, 3'b100, 64'h700, 12'h001, 64'h0, 5'd9, 64'h0000_F100,
           64'h700, 8'hF, 64'h0, 64'h0, 64'h0000_00F1, 1'b1, 2'd0, 64'h701);

    // RV64 unit
    sel64 = 1'b1;
    @(negedge clk);
    run_op("ld", 0, 3'b011, 64'h10, 12'h000, 64'h0, 5'd9, 64'h0123_4567_89AB_CDEF,
           64'h10, 8'hFF, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1, 2'd0, 64'h10);
    run_op("lwu", 0, 3'b110, 64'h10, 12'h004, 64'h0, 5'd9, 64'h0123_4567_89AB_CDEF,
           64'h10, 8'hFF, 64'h0, 64'h0, 64'h0000_0000_0123_4567, 1'b1, 2'd0, 64'h14);
    run_op("lw64", 0, 3'b010, 64'h10, 12'h004, 64'h0, 5'd9, 64'h89AB_CDEF_0000_0000,
           64'h10, 8'hFF, 64'h0, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b1, 2'd0, 64'h14);
    run_op("sd", 1, 3'b011, 64'h8, 12'h000, 64'h1122_3344_5566_7788, 5'd0, 64'h0,
           64'h8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 2'd0, 64'h8);
    run_op("sw64", 1, 3'b010, 64'h18, 12'h004, 64'h0000_0000_CAFE_F00D, 5'd0, 64'h0,
           64'h18, 8'hF0, 64'hFFFF_FFFF_0000_0000, 64'hCAFE_F00D_0000_0000, 64'h0, 1'b0, 2'd0, 64'h1C);
    run_op("ld_mis", 0, 3'b011, 64'h10, 12'h004, 64'h0, 5'd9, 64'h0,
           64'h0, 8'h0, 64'h0, 64'h0, 64'h0, 1'b0, 2'd1, 64'h14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
